booth_ppg: RTL and testbench
============================

BOOTH_PPG -- requirements
Module: booth_ppg

Interface
REQ-001 Parameter REGISTERED, default 0: 0 = combinational outputs; 1 = all outputs registered, one-cycle latency.
REQ-002 One clock; reset is asynchronous and active-low. Ports are named clk and reset, as elsewhere in the codebase.
REQ-003 clk  input  1  clock; used only when REGISTERED=1.
REQ-004 reset  input  1  asynchronous active-low reset; clears output registers when REGISTERED=1.
REQ-005 multiplicand  input  8  signed two's-complement operand A.
REQ-006 multiplier  input  8  signed two's-complement operand B, Booth-recoded.
REQ-007 pp0  output  11  row-0 partial product, with sign-extension prefix.
REQ-008 pp1, pp2, pp3  output  9 each  rows 1..3 partial products, with inverted-sign MSB.
REQ-009 neg0..neg3  output  1 each  +1 correction for a negative row; weight 4^i.

Function
REQ-010 Radix-4 Booth: row i uses triplet (B[2i+1], B[2i], B[2i-1]), with B[-1]=0.
- 000 and 111 -> 0
- 001 and 010 -> +A
- 011 -> +2A
- 100 -> -2A
- 101 and 110 -> -A
REQ-011 Magnitude M_i is 9 bits: 0, sign-extended A, or A<<1.
- Negative digit: p_i = ~M_i (9-bit one's complement), neg_i = 1.
- Otherwise: p_i = M_i, neg_i = 0.
- Triplet 111: p_i = 0, neg_i = 0.
REQ-012 Row sign s_i = p_i[8], taken after inversion. This lets -2A with A=-128 give p=0x0FF, s=0, neg=1, value +256.
REQ-013 pp0 = {~s0, s0, s0, p0[7:0]}.
REQ-014 ppi = {~si, pi[7:0]} for i = 1..3.
REQ-015 Reconstruction invariant, for all 65536 (A,B) pairs: pp0 + pp1*4 + pp2*16 + pp3*64 + neg0 + neg1*4 + neg2*16 + neg3*64 + 0x1A800, taken mod 2^17, SHALL equal the 17-bit signed product A*B.
REQ-016 The constant 0x1A800 equals -(2^14 + 2^12 + 2^11) mod 2^17.
REQ-017 Accumulation of N products SHALL need one correction of N*(-22528). For N=9 this is 0x4E800 mod 2^19.
REQ-018 REGISTERED=0: outputs are pure functions of the inputs, settle within the same cycle, and clk/reset have no effect.
REQ-019 REGISTERED=1: outputs present the REQ-010..014 values for the inputs sampled at the previous rising clk edge. There is no handshake.

Reset
REQ-020 REGISTERED=1: reset low SHALL clear all outputs to 0 immediately, independent of clk. The all-zero pp0 is a reset value, not a valid encoding.
REQ-021 Reset low mid-operation SHALL override the capture in progress.
REQ-022 The first rising clk edge after reset goes high SHALL capture the current inputs.
REQ-023 REGISTERED=0: reset has no functional effect.

Structure
REQ-024 Package booth_ppg_pkg SHALL hold:
- widths: operand 8, pp0 11, ppN 9, product 17
- correction constant 17'h1A800
- per-product correction -22528
- Booth digit enum {ZERO, POS1, POS2, NEG1, NEG2}
REQ-025 One sub-module, booth_row, SHALL take the 3-bit triplet and A, and return p[8:0], s and neg. booth_ppg instantiates it four times.
REQ-026 booth_ppg SHALL add the pp0/ppN prefixes and the optional output register stage.

Verification
REQ-027 A=0, B=0 -> pp0=0x400, pp1..pp3=0x100, neg=0000, reconstruction 0.
REQ-028 A=1, B=1 -> pp0=0x401, pp1..pp3=0x100, neg=0000, reconstruction 1.
REQ-029 A=127, B=127 -> pp0=0x380, neg0=1, pp1=pp2=0x100, pp3=0x1FE, reconstruction 16129.
REQ-030 A=-128, B=-128 -> pp0=0x400, pp1=pp2=0x100, pp3=0x1FF, neg3=1, reconstruction 16384.
REQ-031 Exhaustive sweep of all 256x256 pairs:
- REQ-015 check with zero mismatches
- nine-fold accumulation with 0x4E800 equals 9*A*B mod 2^19 with zero mismatches
REQ-032 REGISTERED=1: drive reset low mid-stream -> outputs 0 at once. Release reset, apply A=127, B=127 -> REQ-029 values after the next rising edge, not before.

Source files
------------

// File: rtl/booth_ppg_pkg.sv
// Shared widths, correction constants and Booth digit decoding for the
// radix-4 partial-product generator.
package booth_ppg_pkg;

    localparam int OP_W   = 8;
    localparam int PP0_W  = 11;
    localparam int PPN_W  = 9;
    localparam int PROD_W = 17;
    localparam int ROWS   = 4;

    // Folds the ~s/s sign-extension prefixes of all four rows back to zero.
    localparam logic [PROD_W-1:0] RECON_CORR = 17'h1A800;

    // The same fold expressed per product, for accumulators wider than 17 bits.
    localparam int ACC_CORR = -22528;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_e;

    function automatic booth_digit_e decode_triplet(input logic [2:0] trip);
        booth_digit_e dig;
        case (trip)
            3'b000:  dig = ZERO;
            3'b001:  dig = POS1;
            3'b010:  dig = POS1;
            3'b011:  dig = POS2;
            3'b100:  dig = NEG2;
            3'b101:  dig = NEG1;
            3'b110:  dig = NEG1;
            3'b111:  dig = ZERO;
            default: dig = ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_ppg_row.sv
// One Booth row: selects 0, A or 2A from the recoded triplet and applies
// one's-complement negation, leaving the +1 to the neg flag.
module booth_row
    import booth_ppg_pkg::*;
(
    input  logic [2:0]       triplet,
    input  logic [OP_W-1:0]  a,
    output logic [PPN_W-1:0] p,
    output logic             s,
    output logic             neg
);

    booth_digit_e     digit_s;
    logic [PPN_W-1:0] mag_s;
    logic             neg_s;

    assign digit_s = decode_triplet(triplet);

    // Magnitude select and negation from the decoded digit.
    always_comb begin
        mag_s = {PPN_W{1'b0}};
        neg_s = 1'b0;
        case (digit_s)
            ZERO: begin
                mag_s = {PPN_W{1'b0}};
                neg_s = 1'b0;
            end
            POS1: begin
                mag_s = {a[OP_W-1], a};
                neg_s = 1'b0;
            end
            POS2: begin
                mag_s = {a, 1'b0};
                neg_s = 1'b0;
            end
            NEG1: begin
                mag_s = {a[OP_W-1], a};
                neg_s = 1'b1;
            end
            NEG2: begin
                mag_s = {a, 1'b0};
                neg_s = 1'b1;
            end
            default: begin
                mag_s = {PPN_W{1'b0}};
                neg_s = 1'b0;
            end
        endcase
    end

    // Sign is read after inversion so -2A with A=-128 stays a positive row.
    assign p   = neg_s ? ~mag_s : mag_s;
    assign s   = p[PPN_W-1];
    assign neg = neg_s;

endmodule

// File: rtl/booth_ppg.sv
// Radix-4 Booth partial-product generator: four recoded rows with
// sign-extension prefixes and an optional output register stage.
module booth_ppg
    import booth_ppg_pkg::*;
#(
    parameter bit REGISTERED = 1'b0
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   multiplicand,
    input  logic [OP_W-1:0]   multiplier,
    output logic [PP0_W-1:0]  pp0,
    output logic [PPN_W-1:0]  pp1,
    output logic [PPN_W-1:0]  pp2,
    output logic [PPN_W-1:0]  pp3,
    output logic              neg0,
    output logic              neg1,
    output logic              neg2,
    output logic              neg3
);

    logic [2:0]       trip_s  [ROWS];
    logic [PPN_W-1:0] row_p_s [ROWS];
    logic [ROWS-1:0]  row_s_s;
    logic [ROWS-1:0]  row_neg_s;

    logic [PP0_W-1:0] pp0_d;
    logic [PPN_W-1:0] pp1_d;
    logic [PPN_W-1:0] pp2_d;
    logic [PPN_W-1:0] pp3_d;
    logic [ROWS-1:0]  neg_d;

    // Overlapping triplets; row 0 sees an implicit zero below bit 0.
    always_comb begin
        trip_s[0] = {multiplier[1], multiplier[0], 1'b0};
        for (int i = 1; i < ROWS; i++) begin
            trip_s[i] = multiplier[2*i+1 -: 3];
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_row
        booth_row u_row (
            .triplet (trip_s[g]),
            .a       (multiplicand),
            .p       (row_p_s[g]),
            .s       (row_s_s[g]),
            .neg     (row_neg_s[g])
        );
    end

    // Attach the sign-extension prefixes to each row.
    always_comb begin
        pp0_d = {~row_s_s[0], row_s_s[0], row_s_s[0], row_p_s[0][7:0]};
        pp1_d = {~row_s_s[1], row_p_s[1][7:0]};
        pp2_d = {~row_s_s[2], row_p_s[2][7:0]};
        pp3_d = {~row_s_s[3], row_p_s[3][7:0]};
        neg_d = row_neg_s;
    end

    if (REGISTERED) begin : g_reg
        logic [PP0_W-1:0] pp0_q;
        logic [PPN_W-1:0] pp1_q;
        logic [PPN_W-1:0] pp2_q;
        logic [PPN_W-1:0] pp3_q;
        logic [ROWS-1:0]  neg_q;

        // Output stage; all-zero while reset is held is not a valid encoding.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pp0_q <= {PP0_W{1'b0}};
                pp1_q <= {PPN_W{1'b0}};
                pp2_q <= {PPN_W{1'b0}};
                pp3_q <= {PPN_W{1'b0}};
                neg_q <= {ROWS{1'b0}};
            end else begin
                pp0_q <= pp0_d;
                pp1_q <= pp1_d;
                pp2_q <= pp2_d;
                pp3_q <= pp3_d;
                neg_q <= neg_d;
            end
        end

        assign pp0  = pp0_q;
        assign pp1  = pp1_q;
        assign pp2  = pp2_q;
        assign pp3  = pp3_q;
        assign neg0 = neg_q[0];
        assign neg1 = neg_q[1];
        assign neg2 = neg_q[2];
        assign neg3 = neg_q[3];
    end else begin : g_comb
        logic unused_clk_rst_s;
        assign unused_clk_rst_s = clk ^ reset;

        assign pp0  = pp0_d;
        assign pp1  = pp1_d;
        assign pp2  = pp2_d;
        assign pp3  = pp3_d;
        assign neg0 = neg_d[0];
        assign neg1 = neg_d[1];
        assign neg2 = neg_d[2];
        assign neg3 = neg_d[3];
    end

endmodule

// File: tb/tb_booth_ppg.sv
// Directed vectors, exhaustive reconstruction sweep and reset sequencing
// for booth_ppg in both combinational and registered builds.
`timescale 1ns/1ps
module tb_booth_ppg;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [10:0] pp0;
        logic [8:0]  pp1;
        logic [8:0]  pp2;
        logic [8:0]  pp3;
        logic [3:0]  neg;
        logic [16:0] prod;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_c, reset_r;
    logic [7:0]  a_c, b_c, a_r, b_r;
    logic [10:0] pp0_c, pp0_r;
    logic [8:0]  pp1_c, pp2_c, pp3_c, pp1_r, pp2_r, pp3_r;
    logic        n0_c, n1_c, n2_c, n3_c, n0_r, n1_r, n2_r, n3_r;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [8];
    vec_t zero_v;

    always #5 clk = ~clk;

    booth_ppg #(.REGISTERED(1'b0)) u_comb (
        .clk(clk), .reset(reset_c), .multiplicand(a_c), .multiplier(b_c),
        .pp0(pp0_c), .pp1(pp1_c), .pp2(pp2_c), .pp3(pp3_c),
        .neg0(n0_c), .neg1(n1_c), .neg2(n2_c), .neg3(n3_c)
    );

    booth_ppg #(.REGISTERED(1'b1)) u_reg (
        .clk(clk), .reset(reset_r), .multiplicand(a_r), .multiplier(b_r),
        .pp0(pp0_r), .pp1(pp1_r), .pp2(pp2_r), .pp3(pp3_r),
        .neg0(n0_r), .neg1(n1_r), .neg2(n2_r), .neg3(n3_r)
    );

    function automatic logic [18:0] raw_sum(input logic [10:0] p0, input logic [8:0] p1,
                                            input logic [8:0] p2, input logic [8:0] p3,
                                            input logic [3:0] n);
        return 19'(p0) + (19'(p1) << 2) + (19'(p2) << 4) + (19'(p3) << 6)
             + 19'(n[0]) + (19'(n[1]) << 2) + (19'(n[2]) << 4) + (19'(n[3]) << 6);
    endfunction

    function automatic logic [16:0] recon(input logic [10:0] p0, input logic [8:0] p1,
                                          input logic [8:0] p2, input logic [8:0] p3,
                                          input logic [3:0] n);
        logic [18:0] r;
        r = raw_sum(p0, p1, p2, p3, n);
        return r[16:0] + 17'h1A800;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [10:0] g0, input logic [8:0] g1,
                           input logic [8:0] g2, input logic [8:0] g3, input logic [3:0] gn,
                           input vec_t e);
        chk({tag, ".pp0"}, 32'(g0), 32'(e.pp0));
        chk({tag, ".pp1"}, 32'(g1), 32'(e.pp1));
        chk({tag, ".pp2"}, 32'(g2), 32'(e.pp2));
        chk({tag, ".pp3"}, 32'(g3), 32'(e.pp3));
        chk({tag, ".neg"}, 32'(gn), 32'(e.neg));
    endtask

    initial begin
        //           a       b       pp0       pp1      pp2      pp3      neg{3..0} product
        vecs[0] = '{8'h00, 8'h00, 11'h400, 9'h100, 9'h100, 9'h100, 4'b0000, 17'd0};
        vecs[1] = '{8'h01, 8'h01, 11'h401, 9'h100, 9'h100, 9'h100, 4'b0000, 17'd1};
        vecs[2] = '{8'h7F, 8'h7F, 11'h380, 9'h100, 9'h100, 9'h1FE, 4'b0001, 17'd16129};
        vecs[3] = '{8'h80, 8'h80, 11'h400, 9'h100, 9'h100, 9'h1FF, 4'b1000, 17'd16384};
        vecs[4] = '{8'h05, 8'hFF, 11'h3FA, 9'h100, 9'h100, 9'h100, 4'b0001, 17'h1FFFB};
        vecs[5] = '{8'hFF, 8'h02, 11'h401, 9'h0FF, 9'h100, 9'h100, 4'b0001, 17'h1FFFE};
        vecs[6] = '{8'h80, 8'h55, 11'h380, 9'h080, 9'h080, 9'h080, 4'b0000, 17'h1D580};
        vecs[7] = '{8'h64, 8'hAA, 11'h337, 9'h09B, 9'h09B, 9'h09B, 4'b1111, 17'h1DE68};
        zero_v  = '{8'h00, 8'h00, 11'h000, 9'h000, 9'h000, 9'h000, 4'b0000, 17'd0};

        reset_c = 1'b1;
        reset_r = 1'b0;
        a_c = 8'h00; b_c = 8'h00;
        a_r = 8'h7F; b_r = 8'h7F;
        #1;
        chk_all("reg_reset_state", pp0_r, pp1_r, pp2_r, pp3_r, {n3_r, n2_r, n1_r, n0_r}, zero_v);

        // Directed table against the combinational build.
        for (int i = 0; i < 8; i++) begin
            a_c = vecs[i].a;
            b_c = vecs[i].b;
            #1;
            chk_all($sformatf("vec%0d", i), pp0_c, pp1_c, pp2_c, pp3_c,
                    {n3_c, n2_c, n1_c, n0_c}, vecs[i]);
            chk($sformatf("vec%0d.recon", i),
                32'(recon(pp0_c, pp1_c, pp2_c, pp3_c, {n3_c, n2_c, n1_c, n0_c})),
                32'(vecs[i].prod));
        end

        // Reset must not disturb the combinational build.
        reset_c = 1'b0;
        a_c = vecs[2].a;
        b_c = vecs[2].b;
        #1;
        chk_all("comb_reset_low", pp0_c, pp1_c, pp2_c, pp3_c, {n3_c, n2_c, n1_c, n0_c}, vecs[2]);
        reset_c = 1'b1;

        // Exhaustive sweep: one reconstruction and one 9-fold accumulation check per A.
        for (int ai = 0; ai < 256; ai++) begin
            int bad_r = 0;
            int bad_a = 0;
            int first_b = -1;
            for (int bi = 0; bi < 256; bi++) begin
                logic [18:0] raw;
                logic [16:0] rc;
                logic [18:0] acc;
                int prod;
                int prod9;
                a_c = 8'(ai);
                b_c = 8'(bi);
                #1;
                raw   = raw_sum(pp0_c, pp1_c, pp2_c, pp3_c, {n3_c, n2_c, n1_c, n0_c});
                rc    = raw[16:0] + 17'h1A800;
                acc   = 19'(raw * 19'd9) + 19'h4E800;
                prod  = int'($signed(a_c)) * int'($signed(b_c));
                prod9 = 9 * prod;
                if (rc !== prod[16:0]) begin
                    bad_r++;
                    if (first_b < 0) first_b = bi;
                end
                if (acc !== prod9[18:0]) begin
                    bad_a++;
                    if (first_b < 0) first_b = bi;
                end
            end
            chk($sformatf("sweep_recon A=%0d (first bad B=%0d)", ai, first_b), 32'(bad_r), 32'd0);
            chk($sformatf("sweep_acc9 A=%0d (first bad B=%0d)", ai, first_b), 32'(bad_a), 32'd0);
        end

        // Registered build: release reset away from the edge, then capture.
        @(negedge clk);
        reset_r = 1'b1;
        a_r = vecs[4].a;
        b_r = vecs[4].b;
        #1;
        chk_all("reg_before_first_edge", pp0_r, pp1_r, pp2_r, pp3_r, {n3_r, n2_r, n1_r, n0_r}, zero_v);
        @(posedge clk);
        #1;
        chk_all("reg_first_capture", pp0_r, pp1_r, pp2_r, pp3_r, {n3_r, n2_r, n1_r, n0_r}, vecs[4]);

        // New inputs must not appear until the next edge.
        a_r = vecs[7].a;
        b_r = vecs[7].b;
        #1;
        chk_all("reg_hold", pp0_r, pp1_r, pp2_r, pp3_r, {n3_r, n2_r, n1_r, n0_r}, vecs[4]);

        // Reset mid-stream clears at once and blocks the pending capture.
        #1;
        reset_r = 1'b0;
        #1;
        chk_all("reg_async_clear", pp0_r, pp1_r, pp2_r, pp3_r, {n3_r, n2_r, n1_r, n0_r}, zero_v);
        @(posedge clk);
        #1;
        chk_all("reg_reset_overrides", pp0_r, pp1_r, pp2_r, pp3_r, {n3_r, n2_r, n1_r, n0_r}, zero_v);

        reset_r = 1'b1;
        a_r = vecs[2].a;
        b_r = vecs[2].b;
        #1;
        chk_all("reg_not_before_edge", pp0_r, pp1_r, pp2_r, pp3_r, {n3_r, n2_r, n1_r, n0_r}, zero_v);
        @(posedge clk);
        #1;
        chk_all("reg_after_release", pp0_r, pp1_r, pp2_r, pp3_r, {n3_r, n2_r, n1_r, n0_r}, vecs[2]);
        chk("reg_after_release.recon",
            32'(recon(pp0_r, pp1_r, pp2_r, pp3_r, {n3_r, n2_r, n1_r, n0_r})), 32'(vecs[2].prod));

        a_r = vecs[3].a;
        b_r = vecs[3].b;
        @(posedge clk);
        #1;
        chk_all("reg_stream", pp0_r, pp1_r, pp2_r, pp3_r, {n3_r, n2_r, n1_r, n0_r}, vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
